// File: rtl/reset_sequencer.sv
// reset_sequencer: power-up / recovery reset sequencing for the SiTCP/Firefly
// link. Waits for a stable PLL lock, pulses the PHY reset, lets the PHY
// settle, then releases the SiTCP core. Lock loss or a soft restart re-runs
// the sequence. All outputs come straight from dedicated flops.
module reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned PHY_RST_CYCLES     = 2048,
    parameter int unsigned PHY_SETTLE_CYCLES  = 4096,
    parameter int unsigned CORE_RST_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       phy_rst_n,
    output logic       sitcp_rst,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        PHY_RESET  = 3'd1,
        PHY_SETTLE = 3'd2,
        CORE_RESET = 3'd3,
        RUN        = 3'd4
    } state_t;

    // Terminal counts, narrowed once to the counter width.
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] PHY_LAST    = 16'(PHY_RST_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(PHY_SETTLE_CYCLES - 1);
    localparam logic [15:0] CORE_LAST   = 16'(CORE_RST_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic lock_p0;
    (* ASYNC_REG = "TRUE" *) logic lock_s;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        in_seq;
    logic        lock_loss;

    // Saturating 8-bit increment for the lock-loss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Bring the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= pll_locked;
            lock_s  <= lock_p0;
        end
    end

    assign in_seq = (state_q == PHY_RESET) || (state_q == PHY_SETTLE) ||
                    (state_q == CORE_RESET) || (state_q == RUN);

    // Next state and shared counter: normal progression first, then soft
    // restart, then lock loss, so lock loss has the final say.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        lock_loss = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = PHY_RESET;
                    cnt_d   = '0;
                end
            end
            PHY_RESET: begin
                if (cnt_q == PHY_LAST) begin
                    state_d = PHY_SETTLE;
                    cnt_d   = '0;
                end
            end
            PHY_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CORE_RESET;
                    cnt_d   = '0;
                end
            end
            CORE_RESET: begin
                if (cnt_q == CORE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        if (in_seq && soft_rst) begin
            state_d = PHY_RESET;
            cnt_d   = '0;
        end

        if (in_seq && !lock_s) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            lock_loss = 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output flops decoded from the next state so they move with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_rst_n <= 1'b0;
            sitcp_rst <= 1'b1;
            ready     <= 1'b0;
        end else begin
            phy_rst_n <= !((state_d == WAIT_LOCK) || (state_d == PHY_RESET));
            sitcp_rst <= (state_d != RUN);
            ready     <= (state_d == RUN);
        end
    end

    // Count lock-loss events, holding at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_loss) begin
            lock_loss_cnt <= sat_inc8(lock_loss_cnt);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for reset_sequencer with short
// sequence lengths (8/20/10/4) and hand-derived edge-by-edge expectations.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       phy_rst_n;
    logic       sitcp_rst;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(8),
        .PHY_RST_CYCLES    (20),
        .PHY_SETTLE_CYCLES (10),
        .CORE_RST_CYCLES   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst     (soft_rst),
        .phy_rst_n    (phy_rst_n),
        .sitcp_rst    (sitcp_rst),
        .ready        (ready),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected state after start-up edge e (lock sampled high from edge 0).
    function automatic int exp_state(input int e);
        if (e < 9)  return 0;
        if (e < 29) return 1;
        if (e < 39) return 2;
        if (e < 43) return 3;
        return 4;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Hold lock high and check every edge of the start-up sequence.
    task automatic run_startup(input int n);
        pll_locked = 1'b1;
        for (int e = 0; e < n; e++) begin
            tick();
            chk("su_state", int'(state), exp_state(e));
            chk("su_phy_rst_n", int'(phy_rst_n), (e >= 29) ? 1 : 0);
            chk("su_sitcp_rst", int'(sitcp_rst), (e >= 43) ? 0 : 1);
            chk("su_ready", int'(ready), (e >= 43) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_state", int'(state), 0);
        chk("rst_phy_rst_n", int'(phy_rst_n), 0);
        chk("rst_sitcp_rst", int'(sitcp_rst), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_llc", int'(lock_loss_cnt), 0);
        rst_n = 1'b1;

        // Power-up
        run_startup(46);
        chk("pwr_llc", int'(lock_loss_cnt), 0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        tick();
        chk("ll_e0_state", int'(state), 4);
        chk("ll_e0_ready", int'(ready), 1);
        tick();
        chk("ll_e1_state", int'(state), 4);
        tick();
        chk("ll_state", int'(state), 0);
        chk("ll_ready", int'(ready), 0);
        chk("ll_sitcp_rst", int'(sitcp_rst), 1);
        chk("ll_phy_rst_n", int'(phy_rst_n), 0);
        chk("ll_llc", int'(lock_loss_cnt), 1);

        // Relock into PHY_SETTLE, then soft restart
        run_startup(32);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("sr_state", int'(state), 1);
        chk("sr_phy_rst_n", int'(phy_rst_n), 0);
        chk("sr_sitcp_rst", int'(sitcp_rst), 1);
        chk("sr_ready", int'(ready), 0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 19) begin
                chk("sr_k19_state", int'(state), 1);
                chk("sr_k19_phy_rst_n", int'(phy_rst_n), 0);
            end
            if (k == 20) begin
                chk("sr_k20_state", int'(state), 2);
                chk("sr_k20_phy_rst_n", int'(phy_rst_n), 1);
            end
        end

        // Lock loss and soft restart on the same edge
        pll_locked = 1'b0;
        tick();
        tick();
        chk("both_pre_state", int'(state), 2);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("both_state", int'(state), 0);
        chk("both_phy_rst_n", int'(phy_rst_n), 0);
        chk("both_llc", int'(lock_loss_cnt), 2);
        tick();
        chk("both_hold_state", int'(state), 0);

        // Asynchronous reset during CORE_RESET
        run_startup(41);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", int'(state), 0);
        chk("ar_phy_rst_n", int'(phy_rst_n), 0);
        chk("ar_sitcp_rst", int'(sitcp_rst), 1);
        chk("ar_ready", int'(ready), 0);
        chk("ar_llc", int'(lock_loss_cnt), 0);
        tick();
        pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;

        // Lock glitch in WAIT_LOCK: high 5, low 1, then high
        for (int e = 0; e < 16; e++) begin
            pll_locked = (e != 5);
            tick();
            chk("gl_state", int'(state), (e < 15) ? 0 : 1);
            chk("gl_phy_rst_n", int'(phy_rst_n), 0);
        end
        chk("gl_llc", int'(lock_loss_cnt), 0);

        // Saturation of the lock-loss counter
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b1;
            repeat (12) tick();
            pll_locked = 1'b0;
            repeat (3) tick();
            if (i == 254) chk("sat_254", int'(lock_loss_cnt), 254);
            if (i == 255) chk("sat_255", int'(lock_loss_cnt), 255);
        end
        chk("sat_300", int'(lock_loss_cnt), 255);
        chk("sat_state", int'(state), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Power-up and recovery reset sequencer for the SiTCP/Firefly link. It sits directly downstream of the board-level reset synchroniser and consumes its synchronous reset, inverted to active-low. It waits for the transceiver PLL to report a stable lock, pulses the PHY reset, waits for the PHY to settle, and then releases the SiTCP core reset. Any loss of lock or software restart re-runs the sequence with glitch-free registered outputs.

## Interface
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock-high cycles required before the sequence starts (1..65535).
- PHY_RST_CYCLES, 2048: cycles `phy_rst_n` is held low in PHY_RESET (1..65535).
- PHY_SETTLE_CYCLES, 4096: cycles between PHY release and core release (1..65535).
- CORE_RST_CYCLES, 16: cycles spent in CORE_RESET before RUN (1..65535).
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst_n`, in, 1: one clock; reset is asynchronous and active-low.
- `pll_locked`, in, 1: PLL lock, asynchronous to `clk`; passes through an internal 2-FF synchroniser (`ASYNC_REG`) to give `lock_s`.
- `soft_rst`, in, 1: synchronous restart request, sampled on each edge.
- `phy_rst_n`, out, 1: PHY reset, active-low.
- `sitcp_rst`, out, 1: SiTCP core reset, active-high.
- `ready`, out, 1: link stack out of reset.
- `state`, out, 3: current state encoding, for debug.
- `lock_loss_cnt`, out, 8: saturating count of lock losses.

## Operation
- States and encodings: WAIT_LOCK=0, PHY_RESET=1, PHY_SETTLE=2, CORE_RESET=3, RUN=4. Other codes are illegal and go to WAIT_LOCK on the next edge.
- A single 16-bit counter `cnt` is shared by all states. It clears to 0 on every state transition.
- WAIT_LOCK:
  - When `lock_s`=1, `cnt` increments.
  - When `lock_s`=0, `cnt` is cleared.
  - On an edge with `lock_s`=1 and `cnt`==LOCK_STABLE_CYCLES-1, go to PHY_RESET.
- PHY_RESET, PHY_SETTLE, CORE_RESET:
  - `cnt` increments every cycle.
  - On the edge where `cnt`==N-1 (N is that state's parameter), advance to the next state.
- RUN: terminal state. It holds until lock loss or `soft_rst`.
- Lock loss: `lock_s`=0 in any state except WAIT_LOCK sends the block to WAIT_LOCK on the next edge. `lock_loss_cnt` increments and saturates at 255.
- Soft restart: `soft_rst`=1 in PHY_RESET, PHY_SETTLE, CORE_RESET or RUN goes to PHY_RESET with `cnt`=0. `soft_rst` is ignored in WAIT_LOCK.
- Priority: lock loss wins over `soft_rst` on the same edge.
- Output decode, one dedicated flop per output, each loaded from the next state:
  - `phy_rst_n`: 0 in WAIT_LOCK and PHY_RESET, otherwise 1.
  - `sitcp_rst`: 1 in every state except RUN.
  - `ready`: 1 only in RUN.

## Timing
- Reset values while `rst_n`=0:
  - `state`=WAIT_LOCK, `cnt`=0, synchroniser flops 0.
  - `phy_rst_n`=0, `sitcp_rst`=1, `ready`=0, `lock_loss_cnt`=0.
- Reset assertion is asynchronous and takes effect immediately. Deassertion is synchronous to the next `clk` edge; the upstream synchroniser guarantees this.
- `rst_n` asserted mid-sequence aborts immediately to the reset values. `lock_loss_cnt` is also cleared.
- Outputs change on the same edge as `state`, with no combinational path from input to output.
- Synchroniser latency: `pll_locked` sampled high at edge E gives `lock_s`=1 after edge E+1.
- Start-up latency from edge E: `ready` rises after edge E+1+LOCK_STABLE+PHY_RST+PHY_SETTLE+CORE_RST. `phy_rst_n` rises CORE_RST+PHY_SETTLE edges earlier.
- Lock-loss latency: `pll_locked` sampled low at edge E drives all outputs to reset values after edge E+2.
- Soft-restart latency: `soft_rst` high at edge E gives `phy_rst_n`=0, `sitcp_rst`=1 and `ready`=0 after edge E.
- A lock glitch shorter than LOCK_STABLE_CYCLES in WAIT_LOCK restarts the stability count. No output changes.

## Test plan
Parameters for all scenarios: LOCK_STABLE=8, PHY_RST=20, PHY_SETTLE=10, CORE_RST=4.
- Power-up: release `rst_n`, then hold `pll_locked`=1 from edge 0. Required:
  - `phy_rst_n` rises after edge 29.
  - `sitcp_rst` falls and `ready` rises after edge 43.
  - `state` steps 0→1 after edge 9, 1→2 after edge 29, 2→3 after edge 39, 3→4 after edge 43.
- Lock glitch in WAIT_LOCK: `pll_locked` high 5 cycles, low 1 cycle, then high. Required: `state` stays 0 until 8 fresh consecutive `lock_s` highs, `lock_loss_cnt`=0, `phy_rst_n` stays 0.
- Lock loss in RUN: drop `pll_locked` at edge E. Required: after edge E+2, `ready`=0, `sitcp_rst`=1, `phy_rst_n`=0, `state`=0, `lock_loss_cnt`=1. The full sequence re-runs when lock returns.
- Soft restart in PHY_SETTLE, plus simultaneous lock loss and `soft_rst`:
  - `soft_rst` pulse in PHY_SETTLE: `state`=1 and `phy_rst_n`=0 next edge, followed by a full 20-cycle PHY reset.
  - Lock loss with `soft_rst` on the same edge: lock loss wins and `state`=0.
- Async reset mid-sequence: assert `rst_n`=0 between clock edges during CORE_RESET. Required: outputs reach reset values before the next edge and `lock_loss_cnt`=0.
- Saturation: force 300 lock-loss events. Required: `lock_loss_cnt`=255 and it does not wrap.
